// File: rtl/qos_scheduler.sv
// Weighted round-robin read scheduler: drains four VC FIFOs into the output FIFO,
// giving each VC up to its latched weight of consecutive grants per turn.
module qos_scheduler #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int MAX_WEIGHT     = 64
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        enb,
  input  logic                                        iniciar,
  input  logic [QUEUE_QUANTITY*$clog2(MAX_WEIGHT)-1:0] pesos,
  input  logic [QUEUE_QUANTITY-1:0]                   vc_empty,
  input  logic                                        out_almost_full,
  input  logic                                        out_full,
  output logic [QUEUE_QUANTITY-1:0]                   rd_en,
  output logic [$clog2(QUEUE_QUANTITY)-1:0]           selector,
  output logic                                        wr_en_out,
  output logic                                        idle
);

  localparam int WW = $clog2(MAX_WEIGHT);
  localparam int PW = $clog2(QUEUE_QUANTITY);

  typedef enum logic {INIT, ACTIVE} state_t;

  state_t                      state_q, state_d;
  logic [WW-1:0]               weight_q [QUEUE_QUANTITY];
  logic [PW-1:0]               ptr_q, ptr_d, ptr_inc;
  logic [WW-1:0]               credit_q, credit_d;
  logic                        load_w;
  logic                        active, back_pressure, grant, skip, others_pending;
  logic [QUEUE_QUANTITY-1:0]   ptr_mask;

  // A zero weight would starve its VC forever, so it is promoted to one.
  function automatic logic [WW-1:0] fix_weight(input logic [WW-1:0] w);
    return (w == '0) ? WW'(1) : w;
  endfunction

  assign active         = (state_q == ACTIVE);
  assign back_pressure  = out_almost_full | out_full;
  assign ptr_inc        = (ptr_q == PW'(QUEUE_QUANTITY - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_mask       = QUEUE_QUANTITY'(1) << ptr_q;
  assign others_pending = |(~vc_empty & ~ptr_mask);

  assign grant = active & enb & ~vc_empty[ptr_q] & (credit_q != '0) & ~back_pressure;
  assign skip  = active & enb & vc_empty[ptr_q] & others_pending & ~back_pressure;

  assign rd_en = grant ? ptr_mask : '0;
  assign idle  = ~active | (&vc_empty & ~wr_en_out);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    load_w   = 1'b0;
    unique case (state_q)
      INIT: begin
        if (iniciar) begin
          state_d  = ACTIVE;
          load_w   = 1'b1;
          ptr_d    = '0;
          credit_d = fix_weight(pesos[WW-1:0]);
        end
      end
      ACTIVE: begin
        // A reload reads the weight registers before this edge's relatch lands.
        load_w = iniciar;
        if (grant) begin
          if (credit_q > WW'(1)) begin
            credit_d = credit_q - 1'b1;
          end else begin
            ptr_d    = ptr_inc;
            credit_d = weight_q[ptr_inc];
          end
        end else if (skip) begin
          ptr_d    = ptr_inc;
          credit_d = weight_q[ptr_inc];
        end
      end
      default: state_d = INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INIT;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  // NOTE: the weight array is small and must read as 0 after reset, so it is reset explicitly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QUEUE_QUANTITY; i++) weight_q[i] <= '0;
    end else if (load_w) begin
      for (int i = 0; i < QUEUE_QUANTITY; i++) weight_q[i] <= fix_weight(pesos[i*WW +: WW]);
    end
  end

  // The read issued at edge N delivers data during cycle N+1, written at edge N+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_out <= 1'b0;
      selector  <= '0;
    end else begin
      wr_en_out <= grant;
      if (grant) selector <= ptr_q;
    end
  end

endmodule

// File: tb/tb_qos_scheduler.sv
// Self-checking bench for qos_scheduler: directed weighted-order and reset cases,
// then randomized traffic against a cycle-level reference model of the scheduling rules.
module tb_qos_scheduler;

  localparam int QQ = 4;
  localparam int WW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            enb;
  logic            iniciar;
  logic [QQ*WW-1:0] pesos;
  logic [QQ-1:0]   vc_empty;
  logic            out_almost_full;
  logic            out_full;
  logic [QQ-1:0]   rd_en;
  logic [1:0]      selector;
  logic            wr_en_out;
  logic            idle;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  bit m_active;
  int m_w [QQ];
  int m_ptr, m_credit, m_sel;
  bit m_wr;

  qos_scheduler #(.QUEUE_QUANTITY(QQ), .MAX_WEIGHT(64)) dut (
    .clk(clk), .rst(rst), .enb(enb), .iniciar(iniciar), .pesos(pesos),
    .vc_empty(vc_empty), .out_almost_full(out_almost_full), .out_full(out_full),
    .rd_en(rd_en), .selector(selector), .wr_en_out(wr_en_out), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fixw(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic bit model_grant();
    return m_active && enb && !vc_empty[m_ptr] && !out_almost_full && !out_full;
  endfunction

  task automatic model_reset();
    m_active = 0; m_ptr = 0; m_credit = 0; m_wr = 0; m_sel = 0;
    for (int i = 0; i < QQ; i++) m_w[i] = 0;
  endtask

  // Compare DUT outputs against the model mid-cycle, after inputs have settled.
  task automatic settle_and_check();
    bit g;
    #1;
    g = model_grant();
    check("rd_en", rd_en, g ? (32'd1 << m_ptr) : 32'd0);
    check("rd_en_to_empty", rd_en & vc_empty, 0);
    check("wr_en_out", wr_en_out, m_wr);
    check("selector", selector, m_sel);
    check("idle", idle, (!m_active) || (vc_empty == '1 && !m_wr));
  endtask

  // Apply the scheduling rules for the coming edge, then take the edge.
  task automatic advance();
    bit g, others;
    int nxt;
    g = model_grant();
    nxt = (m_ptr + 1) % QQ;
    others = 0;
    for (int i = 0; i < QQ; i++) if (i != m_ptr && !vc_empty[i]) others = 1;
    if (!m_active) begin
      if (iniciar) begin
        for (int i = 0; i < QQ; i++) m_w[i] = fixw(int'(pesos[i*WW +: WW]));
        m_ptr = 0; m_credit = m_w[0]; m_active = 1;
      end
    end else begin
      if (g) begin
        m_sel = m_ptr;
        if (m_credit > 1) m_credit--;
        else begin m_ptr = nxt; m_credit = m_w[nxt]; end
      end else if (enb && vc_empty[m_ptr] && others && !out_almost_full && !out_full) begin
        m_ptr = nxt; m_credit = m_w[nxt];
      end
      if (iniciar) for (int i = 0; i < QQ; i++) m_w[i] = fixw(int'(pesos[i*WW +: WW]));
    end
    m_wr = g;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    enb = 1'($urandom); iniciar = 1'($urandom); pesos = QQ*WW'($urandom);
    vc_empty = QQ'($urandom); out_almost_full = 1'($urandom); out_full = 1'($urandom);
    #1;
    model_reset();
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en_out", wr_en_out, 0);
    check("rst_selector", selector, 0);
    check("rst_idle", idle, 1);
    @(negedge clk);
    rst = 1'b1; iniciar = 1'b0; enb = 1'b1;
    out_almost_full = 1'b0; out_full = 1'b0;
  endtask

  initial begin
    int seq [10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
    rst = 1'b0; enb = 1'b0; iniciar = 1'b0; pesos = '0;
    vc_empty = '1; out_almost_full = 1'b0; out_full = 1'b0;
    model_reset();

    // Directed weighted order: VC3..VC0 weights 1,2,1,3, all VCs backlogged.
    do_reset();
    @(negedge clk);
    pesos = {6'd1, 6'd2, 6'd1, 6'd3}; iniciar = 1'b1; vc_empty = '0;
    settle_and_check();
    advance();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iniciar = 1'b0;
      settle_and_check();
      check("wrr_order", rd_en, 32'd1 << seq[i]);
      advance();
    end

    // Async reset right after a grant: the in-flight word must be dropped at once.
    @(negedge clk);
    #1;
    check("inflight_before_rst", wr_en_out, 1);
    rst = 1'b0;
    #1;
    check("midrst_wr_en_out", wr_en_out, 0);
    check("midrst_idle", idle, 1);
    check("midrst_rd_en", rd_en, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic, starting from INIT.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      enb             = ($urandom_range(0, 9) != 0);
      iniciar         = m_active ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) == 0);
      for (int i = 0; i < QQ; i++)
        pesos[i*WW +: WW] = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 5));
      vc_empty        = ($urandom_range(0, 9) == 0) ? '1 : QQ'($urandom) & QQ'($urandom);
      out_almost_full = ($urandom_range(0, 9) == 0);
      out_full        = ($urandom_range(0, 19) == 0);
      settle_and_check();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
